// File: rtl/pkt_bus_arbiter.sv
// pkt_bus_arbiter: round-robin merge of two packet ports onto one bus; optional truncation via PKT_ARB_MAXLEN_EN.
// Latency: 1 cycle, each accepted word is registered onto out_data/out_state/out_stop.
// Backpressure: only the granted port sees rdy high; the other port holds its word until granted.
module pkt_bus_arbiter #(
    parameter int DATA_W    = 80,
    parameter int CNT_W     = 16,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_state,
    input  logic              in0_stop,
    output logic              in0_rdy,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_state,
    input  logic              in1_stop,
    output logic              in1_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_state,
    output logic              out_stop,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_rr_last;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_state;
    logic                r_out_stop;
    logic [CNT_W-1:0]    r_cnt0;
    logic [CNT_W-1:0]    r_cnt1;

    logic                w_acc0;
    logic                w_acc1;
    logic                w_acc;
    logic                w_stop;
    logic                w_last;
    logic                w_fwd;
    logic                w_out_stop;
    logic [DATA_W-1:0]   w_dat;

    assign in0_rdy   = (r_state == GRANT0);
    assign in1_rdy   = (r_state == GRANT1);
    assign w_acc0    = in0_state & in0_rdy;
    assign w_acc1    = in1_state & in1_rdy;
    assign w_acc     = w_acc0 | w_acc1;
    assign w_dat     = (r_state == GRANT1) ? in1_data : in0_data;
    assign w_stop    = (r_state == GRANT1) ? in1_stop : in0_stop;
    assign w_last    = w_acc & w_stop;

    if (MAX_WORDS < 1) begin : g_max_words_invalid
    end

`ifdef PKT_ARB_MAXLEN_EN
    localparam int WC_W = $clog2(MAX_WORDS + 1);

    logic [WC_W-1:0] r_wcnt;
    logic            r_drop;
    logic            w_cap;

    // Once the cap is hit the rest of the input packet is drained but not forwarded.
    assign w_fwd      = w_acc & ~r_drop;
    assign w_cap      = w_fwd && (r_wcnt == WC_W'(MAX_WORDS - 1));
    assign w_out_stop = w_fwd & (w_stop | w_cap);

    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) begin
            r_wcnt <= '0;
            r_drop <= 1'b0;
        end else if (w_fwd) begin
            r_wcnt <= r_wcnt + WC_W'(1);
            if (w_cap && !w_stop) begin
                r_drop <= 1'b1;
            end
        end
    end
`else
    assign w_fwd      = w_acc;
    assign w_out_stop = w_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_last   <= 1'b1;
            r_out_data  <= '0;
            r_out_state <= 1'b0;
            r_out_stop  <= 1'b0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
        end else begin
            case (r_state)
                // Tie goes to the port that did not win the previous arbitration.
                IDLE: begin
                    if (in0_state && (!in1_state || r_rr_last)) begin
                        r_state   <= GRANT0;
                        r_rr_last <= 1'b0;
                    end else if (in1_state) begin
                        r_state   <= GRANT1;
                        r_rr_last <= 1'b1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (w_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            r_out_state <= w_fwd;
            r_out_stop  <= w_out_stop;
            if (w_fwd) begin
                r_out_data <= w_dat;
            end

            if (w_acc0 && in0_stop) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
            if (w_acc1 && in1_stop) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_state = r_out_state;
    assign out_stop  = r_out_stop;
    assign pkt_cnt0  = r_cnt0;
    assign pkt_cnt1  = r_cnt1;

endmodule

// File: doc/pkt_bus_arbiter.md
PKT_BUS_ARBITER -- requirements
Module: pkt_bus_arbiter

Interface
REQ-001 Parameter DATA_W, default 80, packet bus word width in bits (multiple of 8).
REQ-002 Parameter CNT_W, default 16, width of per-port packet counters.
REQ-003 Parameter MAX_WORDS, default 64, maximum words per output packet; used only when PKT_ARB_MAXLEN_EN is defined.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in0_data  in  DATA_W  port 0 packet word.
REQ-007 in0_state  in  1  port 0 word valid; high for every word of a packet.
REQ-008 in0_stop  in  1  port 0 last word of packet; meaningful only with in0_state.
REQ-009 in0_rdy  out  1  port 0 word accepted this cycle when in0_state && in0_rdy.
REQ-010 in1_data, in1_state, in1_stop, in1_rdy: same as REQ-006..009 for port 1.
REQ-011 out_data  out  DATA_W  merged bus word.
REQ-012 out_state  out  1  out_data valid.
REQ-013 out_stop  out  1  last word of output packet.
REQ-014 pkt_cnt0, pkt_cnt1  out  CNT_W  packets forwarded per port, counted on accepted stop.

Function
REQ-015 FSM states IDLE, GRANT0, GRANT1; in0_rdy = (state==GRANT0), in1_rdy = (state==GRANT1); no other gating.
REQ-016 IDLE: no state inputs high -> stay; one high -> GRANT of that port next cycle; both high -> grant port != rr_last.
REQ-017 rr_last updates to the granted port on each IDLE->GRANTn transition.
REQ-018 GRANTn: stays until a word with stop is accepted from port n, then IDLE next cycle; other port ignored and held (rdy low).
REQ-019 Source holds data/state/stop stable while state high and rdy low; no word is lost or duplicated.
REQ-020 Accepted word appears on out_data/out_state/out_stop exactly one cycle later (registered, latency 1).
REQ-021 Cycle with no accepted word: out_state=0, out_stop=0, out_data holds last value.
REQ-022 In-packet gap (state low while granted, no stop yet): grant held, out_state=0 that cycle.
REQ-023 Minimum gap between output packets: one cycle with out_state=0 (IDLE arbitration cycle).
REQ-024 Stop with state low is ignored.
REQ-025 pkt_cntN increments by 1 per accepted stop from port N; wraps from 2^CNT_W-1 to 0.

Reset
REQ-026 While rst high: state=IDLE, rr_last=1 (port 0 wins first tie), out_data=0, out_state=0, out_stop=0, pkt_cnt0=pkt_cnt1=0, in0_rdy=in1_rdy=0.
REQ-027 Reset mid-packet: output packet is abandoned without stop; first post-reset cycle is IDLE.

Configuration
REQ-028 Macro PKT_ARB_MAXLEN_EN defined: word counter per grant; the MAX_WORDS-th accepted word is forwarded with out_stop=1; remaining words of that input packet accepted (rdy high) and dropped until input stop, then IDLE; truncated packet still increments pkt_cntN once.
REQ-029 PKT_ARB_MAXLEN_EN undefined: no length counter or truncation logic; packets of any length pass unchanged.

Verification
REQ-030 Port 0 only, 4-word packet 0x09..00, 0x19..10, 0x29..20, 0x39..30 with stop on word 4 -> out_state 4 cycles starting 1 cycle after first accept, out_stop on 0x39..30, pkt_cnt0=1.
REQ-031 Both ports request in same IDLE cycle after reset -> port 0 packet output first, port 1 next after exactly one idle cycle; next tie grants port 0 again (alternation).
REQ-032 Port 1 raises state while port 0 mid-packet -> in1_rdy low, port 1 data held, output never interleaves words of both ports.
REQ-033 rst asserted on word 2 of a port 0 packet -> next cycle all outputs 0, counters 0; restarted packet output intact.
REQ-034 pkt_cnt0 preloaded by 65535 packets (CNT_W=16) plus one more -> pkt_cnt0=0.
REQ-035 With PKT_ARB_MAXLEN_EN, MAX_WORDS=2, 4-word packet -> 2 output words, out_stop on word 2, words 3-4 dropped, pkt_cnt0=1.
